imem_responder: RTL and testbench

- Instruction-memory responder serving the fetch stage over a valid/ready request/response handshake.
- Accepts word-aligned byte addresses, returns the 32-bit instruction after a fixed pipeline latency, and buffers responses under back-pressure.
- Supports redirect flushes and a program-load write port.
- Sits between the fetch PC logic and the instruction RAM.

---
 rtl/imem_responder.sv | 149 ++++++++++++++
 tb/tb_imem_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder
//   Instruction-memory responder for the fetch stage. Requests carry a byte
//   address; the addressed 32-bit word is sampled from the instruction RAM
//   when the request is accepted. It then travels through a LATENCY-1 stage
//   pipeline into a show-ahead response FIFO. Acceptance is credit-gated on
//   the outstanding count (pipeline + FIFO), so the FIFO can never overflow.
//   Assumes ADDR_WIDTH < 32.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   req_valid/ready   request handshake; req_addr is the byte address
//   resp_valid/ready  response handshake; resp_instr/resp_err show FIFO head
//   flush             drop everything in flight and buffered
//   ld_en/addr/data   program-load write port into the instruction RAM
module imem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_instr,
  output logic                  resp_err,
  input  logic                  flush,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [31:0]           ld_data
);

  localparam int WORDS  = 1 << (ADDR_WIDTH - 2);
  localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
  localparam int STAGES = LATENCY - 1;

  logic [31:0]           mem [WORDS];
  logic                  accept;
  logic                  acc_err;
  logic [31:0]           acc_instr;
  logic                  push;
  logic                  push_err;
  logic [31:0]           push_instr;
  logic                  pop;
  logic [31:0]           fifo_instr [RESP_DEPTH];
  logic [RESP_DEPTH-1:0] fifo_err;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      outstanding;
  logic                  unused_ld_bits;

  assign unused_ld_bits = ^ld_addr[1:0];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Instruction RAM: contents survive reset so a loaded program stays valid.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr[ADDR_WIDTH-1:2]] <= ld_data;
  end

  // Loads and requests never share a cycle (ld_en blocks req_ready), so the
  // read below never collides with a write to the same word.
  assign req_ready = !rst && !flush && !ld_en && (outstanding < CNT_W'(RESP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign acc_err   = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_WIDTH] != '0);
  assign acc_instr = acc_err ? 32'h0 : mem[req_addr[ADDR_WIDTH-1:2]];

  generate
    if (STAGES == 0) begin : g_direct
      assign push       = accept;
      assign push_instr = acc_instr;
      assign push_err   = acc_err;
    end else begin : g_pipe
      logic [STAGES-1:0] valid_q;
      logic [STAGES-1:0] err_q;
      logic [31:0]       instr_q [STAGES];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= '0;
          err_q   <= '0;
          for (int i = 0; i < STAGES; i++) instr_q[i] <= '0;
        end else if (flush) begin
          valid_q <= '0;
        end else begin
          valid_q[0] <= accept;
          err_q[0]   <= acc_err;
          instr_q[0] <= acc_instr;
          for (int i = 1; i < STAGES; i++) begin
            valid_q[i] <= valid_q[i-1];
            err_q[i]   <= err_q[i-1];
            instr_q[i] <= instr_q[i-1];
          end
        end
      end

      assign push       = valid_q[STAGES-1];
      assign push_instr = instr_q[STAGES-1];
      assign push_err   = err_q[STAGES-1];
    end
  endgenerate

  assign resp_valid = (fifo_count != '0);
  assign pop        = resp_valid && resp_ready;
  assign resp_instr = resp_valid ? fifo_instr[rd_ptr] : 32'h0;
  assign resp_err   = resp_valid ? fifo_err[rd_ptr] : 1'b0;

  // FIFO payload needs no reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      fifo_instr[wr_ptr] <= push_instr;
      fifo_err[wr_ptr]   <= push_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  localparam int ADDR_WIDTH = 12;
  localparam int LATENCY    = 2;
  localparam int RESP_DEPTH = 4;

  logic                  clk;
  logic                  rst;
  logic                  req_valid;
  logic                  req_ready;
  logic [31:0]           req_addr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_instr;
  logic                  resp_err;
  logic                  flush;
  logic                  ld_en;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [31:0]           ld_data;

  int checks = 0;
  int errors = 0;
  bit model_on = 0;

  imem_responder #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LATENCY(LATENCY),
    .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_instr(resp_instr),
    .resp_err(resp_err),
    .flush(flush),
    .ld_en(ld_en),
    .ld_addr(ld_addr),
    .ld_data(ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a word array, a queue of accepted responses waiting
  // for their landing edge, and a queue of responses visible to fetch.
  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          due;
  } entry_t;

  logic [31:0] model_mem [1024];
  entry_t      pending[$];
  entry_t      visible[$];
  int          edge_no = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pending.delete();
      visible.delete();
    end else begin
      bit     pop_now;
      bit     acc_now;
      entry_t e;
      edge_no++;
      pop_now = (visible.size() > 0) && resp_ready;
      acc_now = req_valid && !flush && !ld_en &&
                ((pending.size() + visible.size()) < RESP_DEPTH);
      if (flush) begin
        pending.delete();
        visible.delete();
      end else begin
        if (pop_now) void'(visible.pop_front());
        while (pending.size() > 0 && pending[0].due <= edge_no)
          visible.push_back(pending.pop_front());
        if (acc_now) begin
          e.err   = ((req_addr % 4) != 0) || (req_addr >= (32'd1 << ADDR_WIDTH));
          e.instr = e.err ? 32'h0 : model_mem[(req_addr % 4096) / 4];
          e.due   = edge_no + LATENCY - 1;
          if (LATENCY == 1) visible.push_back(e);
          else pending.push_back(e);
        end
      end
      if (ld_en) model_mem[int'(ld_addr) / 4] = ld_data;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle, away from the rising edge, the DUT must match the model.
  always @(negedge clk) begin
    if (model_on) begin
      logic        exp_ready;
      logic        exp_valid;
      logic [31:0] exp_instr;
      logic        exp_err;
      exp_ready = !rst && !flush && !ld_en &&
                  ((pending.size() + visible.size()) < RESP_DEPTH);
      exp_valid = (visible.size() > 0);
      exp_instr = exp_valid ? visible[0].instr : 32'h0;
      exp_err   = exp_valid ? visible[0].err : 1'b0;
      checkOutput("model req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
      checkOutput("model resp_valid", {31'b0, resp_valid}, {31'b0, exp_valid});
      checkOutput("model resp_instr", resp_instr, exp_instr);
      checkOutput("model resp_err", {31'b0, resp_err}, {31'b0, exp_err});
    end
  end

  // Drives one cycle of inputs, lets one rising edge happen, returns 1ns later.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic rr,
                               input logic fl, input logic ld,
                               input logic [ADDR_WIDTH-1:0] la, input logic [31:0] ld_d);
    req_valid  = v;
    req_addr   = a;
    resp_ready = rr;
    flush      = fl;
    ld_en      = ld;
    ld_addr    = la;
    ld_data    = ld_d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rr);
    applyStimulus(1'b0, 32'h0, rr, 1'b0, 1'b0, '0, 32'h0);
  endtask

  task automatic request(input logic [31:0] a, input logic rr);
    applyStimulus(1'b1, a, rr, 1'b0, 1'b0, '0, 32'h0);
  endtask

  task automatic load(input logic [ADDR_WIDTH-1:0] la, input logic [31:0] d);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, la, d);
  endtask

  task automatic checkHead(input string name, input logic v, input logic [31:0] instr,
                           input logic err);
    checkOutput({name, " valid"}, {31'b0, resp_valid}, {31'b0, v});
    checkOutput({name, " instr"}, resp_instr, instr);
    checkOutput({name, " err"}, {31'b0, resp_err}, {31'b0, err});
  endtask

  logic [31:0] words [4] = '{32'h11111111, 32'h22222222, 32'hAAAAAAAA, 32'h44444444};

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = 32'h0; resp_ready = 1'b0;
    flush = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = 32'h0;
    model_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkHead("reset", 1'b0, 32'h0, 1'b0);
    checkOutput("reset req_ready", {31'b0, req_ready}, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("post-reset req_ready", {31'b0, req_ready}, 32'h1);

    for (int i = 0; i < 4; i++) load(ADDR_WIDTH'(4 * i), words[i]);
    load(12'h010, 32'h00000013);

    $display("[TB] basic fetch");
    request(32'h10, 1'b1);
    checkHead("t1 after accept", 1'b0, 32'h0, 1'b0);
    idle(1'b1);
    checkHead("t1 landed", 1'b1, 32'h00000013, 1'b0);
    idle(1'b1);
    checkHead("t1 drained", 1'b0, 32'h0, 1'b0);
    checkOutput("t1 req_ready", {31'b0, req_ready}, 32'h1);

    $display("[TB] back-pressure");
    for (int i = 0; i < 4; i++) request(32'(4 * i), 1'b0);
    checkOutput("t2 credits exhausted", {31'b0, req_ready}, 32'h0);
    checkHead("t2 head", 1'b1, 32'h11111111, 1'b0);
    request(32'h10, 1'b0);
    request(32'h10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkHead("t2 ordered", 1'b1, words[i], 1'b0);
      idle(1'b1);
    end
    checkHead("t2 drained", 1'b0, 32'h0, 1'b0);
    checkOutput("t2 req_ready back", {31'b0, req_ready}, 32'h1);

    $display("[TB] throughput");
    for (int i = 0; i < 4; i++) begin
      request(32'(4 * i), 1'b1);
      if (i > 0) checkHead("t2b streaming", 1'b1, words[i-1], 1'b0);
    end
    idle(1'b1);
    checkHead("t2b last", 1'b1, words[3], 1'b0);
    idle(1'b1);

    $display("[TB] error paths");
    request(32'h12, 1'b1);
    request(32'h1000, 1'b1);
    checkHead("t3 misaligned", 1'b1, 32'h0, 1'b1);
    request(32'h10, 1'b1);
    checkHead("t3 out of range", 1'b1, 32'h0, 1'b1);
    idle(1'b1);
    checkHead("t3 in order", 1'b1, 32'h00000013, 1'b0);
    idle(1'b1);

    $display("[TB] flush");
    request(32'h0, 1'b0);
    request(32'h4, 1'b0);
    request(32'h8, 1'b0);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b1, 1'b0, '0, 32'h0);
    checkOutput("t4 flush req_ready", {31'b0, req_ready}, 32'h0);
    checkHead("t4 after flush", 1'b0, 32'h0, 1'b0);
    repeat (3) idle(1'b1);
    checkHead("t4 no stale", 1'b0, 32'h0, 1'b0);
    request(32'h4, 1'b1);
    idle(1'b1);
    checkHead("t4 fresh", 1'b1, 32'h22222222, 1'b0);
    idle(1'b1);

    $display("[TB] load after accept");
    request(32'h8, 1'b0);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 1'b1, 12'h008, 32'hBBBBBBBB);
    checkOutput("t5 load req_ready", {31'b0, req_ready}, 32'h0);
    checkHead("t5 old word", 1'b1, 32'hAAAAAAAA, 1'b0);
    idle(1'b1);
    request(32'h8, 1'b1);
    idle(1'b1);
    checkHead("t5 new word", 1'b1, 32'hBBBBBBBB, 1'b0);
    idle(1'b1);

    $display("[TB] async reset");
    request(32'h0, 1'b0);
    request(32'h4, 1'b0);
    idle(1'b0);
    checkHead("t6 buffered", 1'b1, 32'h11111111, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkHead("t6 async clear", 1'b0, 32'h0, 1'b0);
    checkOutput("t6 reset req_ready", {31'b0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("t6 released req_ready", {31'b0, req_ready}, 32'h1);
    request(32'h10, 1'b1);
    idle(1'b1);
    checkHead("t6 memory kept", 1'b1, 32'h00000013, 1'b0);
    idle(1'b1);
    idle(1'b1);

    model_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
